opb_config_sequencer: RTL and testbench

- Controller that loads configuration words into a tile's latch-based config chain, where config latches alternate between two enables (phase A, phase B) and data enters at CONFin and leaves at CONFout.
- Accepts one NBITS word per valid/ready handshake. Serialises it MSB-first onto CONFin and generates non-overlapping phase A / phase B enable pulses.
- Captures the bit emerging at CONFout for each bit slot, so the previous chain contents are read back while the new word is loaded.
- Sits between the fabric configuration port and the per-tile chains, e.g. the chain feeding the I/O pass-through register-select bits.

---
 rtl/opb_cfg_pkg.sv | 23 ++
 rtl/opb_config_sequencer_if.sv | 26 ++
 rtl/opb_phase_timer.sv | 32 +++
 rtl/opb_config_sequencer.sv | 128 ++++++++++++
 tb/tb_opb_config_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/opb_cfg_pkg.sv
// Shared types for the config-chain sequencer: FSM state encoding and
// cycle-count helpers for a per-bit load.
package opb_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      PH_A  = 3'd2,
      GAP_A = 3'd3,
      PH_B  = 3'd4,
      GAP_B = 3'd5,
      DONE  = 3'd6
   } state_e;

   function automatic int bit_cycles(input int pulse_w, input int gap_w);
      return 1 + 2 * pulse_w + 2 * gap_w;
   endfunction

   function automatic int load_cycles(input int nbits, input int pulse_w, input int gap_w);
      return nbits * bit_cycles(pulse_w, gap_w) + 1;
   endfunction

endpackage

// File: rtl/opb_config_sequencer_if.sv
// Word handshake plus serial chain connections between the fabric config
// port, the sequencer and one tile's latch chain.
interface opb_config_sequencer_if #(
   parameter int NBITS = 4
);
   logic [NBITS-1:0] cfg_data;
   logic             cfg_valid;
   logic             cfg_ready;
   logic             CONFin;
   logic             phase_a;
   logic             phase_b;
   logic             CONFout;
   logic [NBITS-1:0] rb_data;
   logic             done;
   logic             busy;

   modport slave (
      input  cfg_data, cfg_valid, CONFout,
      output cfg_ready, CONFin, phase_a, phase_b, rb_data, done, busy
   );

   modport master (
      output cfg_data, cfg_valid, CONFout,
      input  cfg_ready, CONFin, phase_a, phase_b, rb_data, done, busy
   );
endinterface

// File: rtl/opb_phase_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero, so a
// load of N-1 yields a state that lasts N cycles.
module opb_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             tc_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/opb_config_sequencer.sv
// Serialises one config word MSB-first into a two-phase latch chain with
// non-overlapping enables, reading the old chain contents back in parallel.
module opb_config_sequencer
   import opb_cfg_pkg::*;
#(
   parameter int NBITS   = 4,
   parameter int PULSE_W = 1,
   parameter int GAP_W   = 1,
   parameter int CNT_W   = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   opb_config_sequencer_if.slave bus
);
   localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

   state_e           state_q, state_d;
   logic [NBITS-1:0] sh_q, sh_d;
   logic [NBITS-1:0] rb_shift_q, rb_shift_d;
   logic [NBITS-1:0] rb_data_q, rb_data_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_tc;

   opb_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk_i      (CLK),
      .rst_i      (RESET),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .tc_o       (tmr_tc)
   );

   // Every state transition reloads the timer with the new state's length minus one
   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      idx_d      = idx_q;
      rb_shift_d = rb_shift_q;
      rb_data_d  = rb_data_q;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.cfg_valid) begin
               sh_d     = bus.cfg_data;
               idx_d    = IDX_W'(NBITS - 1);
               state_d  = SETUP;
               tmr_load = 1'b1;
            end
         end
         SETUP: begin
            if (tmr_tc) begin
               rb_shift_d = (rb_shift_q << 1) | NBITS'(bus.CONFout);
               state_d    = PH_A;
               tmr_load   = 1'b1;
               tmr_val    = PULSE_LD;
            end
         end
         PH_A: begin
            if (tmr_tc) begin
               state_d  = GAP_A;
               tmr_load = 1'b1;
               tmr_val  = GAP_LD;
            end
         end
         GAP_A: begin
            if (tmr_tc) begin
               state_d  = PH_B;
               tmr_load = 1'b1;
               tmr_val  = PULSE_LD;
            end
         end
         PH_B: begin
            if (tmr_tc) begin
               state_d  = GAP_B;
               tmr_load = 1'b1;
               tmr_val  = GAP_LD;
            end
         end
         GAP_B: begin
            if (tmr_tc) begin
               if (idx_q == '0) begin
                  state_d   = DONE;
                  rb_data_d = rb_shift_q;
               end else begin
                  idx_d    = idx_q - IDX_W'(1);
                  sh_d     = sh_q << 1;
                  state_d  = SETUP;
                  tmr_load = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         sh_q      <= '0;
         idx_q     <= '0;
         rb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         idx_q     <= idx_d;
         rb_data_q <= rb_data_d;
      end
   end

   // Fully rewritten by each load before use, so it needs no reset
   always_ff @(posedge CLK) begin
      rb_shift_q <= rb_shift_d;
   end

   // CONFin follows the shift register MSB, which only moves on SETUP entry
   assign bus.CONFin    = sh_q[NBITS-1];
   assign bus.phase_a   = (state_q == PH_A);
   assign bus.phase_b   = (state_q == PH_B);
   assign bus.done      = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.cfg_ready = (state_q == IDLE) && !RESET;
   assign bus.rb_data   = rb_data_q;
endmodule

// File: tb/tb_opb_config_sequencer.sv
// Bench for opb_config_sequencer: three parameterisations driven against a
// word-level reference of the load timing and a 4-latch A/B chain.
module tb_opb_config_sequencer;
   localparam int ND = 3;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   logic [31:0]   dat [ND];
   logic          vld [ND];
   logic [ND-1:0] rdy, cin, pa, pb, cout, don, bsy;
   logic [31:0]   rb  [ND];

   logic [3:0]    lat  [ND];
   logic [3:0]    mlat [ND];
   logic [31:0]   exp_rb [ND];
   logic          chain_init = 1'b1;
   logic          mon_en = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   opb_config_sequencer_if #(.NBITS(4)) if0 ();
   opb_config_sequencer_if #(.NBITS(4)) if1 ();
   opb_config_sequencer_if #(.NBITS(1)) if2 ();

   opb_config_sequencer #(.NBITS(4), .PULSE_W(1), .GAP_W(1)) u_dut0 (.CLK(CLK), .RESET(RESET), .bus(if0));
   opb_config_sequencer #(.NBITS(4), .PULSE_W(3), .GAP_W(2)) u_dut1 (.CLK(CLK), .RESET(RESET), .bus(if1));
   opb_config_sequencer #(.NBITS(1), .PULSE_W(1), .GAP_W(1)) u_dut2 (.CLK(CLK), .RESET(RESET), .bus(if2));

   assign if0.cfg_data = dat[0][3:0];
   assign if1.cfg_data = dat[1][3:0];
   assign if2.cfg_data = dat[2][0:0];
   assign if0.cfg_valid = vld[0];
   assign if1.cfg_valid = vld[1];
   assign if2.cfg_valid = vld[2];
   assign if0.CONFout = cout[0];
   assign if1.CONFout = cout[1];
   assign if2.CONFout = cout[2];
   assign cout[0] = lat[0][3];
   assign cout[1] = lat[1][3];
   assign cout[2] = lat[2][3];

   assign rdy = {if2.cfg_ready, if1.cfg_ready, if0.cfg_ready};
   assign cin = {if2.CONFin,    if1.CONFin,    if0.CONFin};
   assign pa  = {if2.phase_a,   if1.phase_a,   if0.phase_a};
   assign pb  = {if2.phase_b,   if1.phase_b,   if0.phase_b};
   assign don = {if2.done,      if1.done,      if0.done};
   assign bsy = {if2.busy,      if1.busy,      if0.busy};
   assign rb[0] = 32'(if0.rb_data);
   assign rb[1] = 32'(if1.rb_data);
   assign rb[2] = 32'(if2.rb_data);

   function automatic int nb_of(input int k); return (k == 2) ? 1 : 4; endfunction
   function automatic int pw_of(input int k); return (k == 1) ? 3 : 1; endfunction
   function automatic int gw_of(input int k); return (k == 1) ? 2 : 1; endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {rb_data, pad, busy, done, phase_a, phase_b, CONFin, cfg_ready}
   function automatic logic [63:0] pack(input logic [31:0] rbv, input logic bz, input logic dn,
                                        input logic a, input logic b, input logic ci, input logic rd);
      return {rbv, 26'd0, bz, dn, a, b, ci, rd};
   endfunction

   function automatic logic [63:0] snap(input int k);
      return pack(rb[k], bsy[k], don[k], pa[k], pb[k], cin[k], rdy[k]);
   endfunction

   // Physical chain: L0/L2 open on phase A, L1/L3 open on phase B
   always @(posedge CLK) begin
      for (int k = 0; k < ND; k++) begin
         if (chain_init) begin
            lat[k] <= 4'b0110;
         end else begin
            if (pa[k]) begin
               lat[k][0] <= cin[k];
               lat[k][2] <= lat[k][1];
            end
            if (pb[k]) begin
               lat[k][1] <= lat[k][0];
               lat[k][3] <= lat[k][2];
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (mon_en) begin
         for (int k = 0; k < ND; k++) check("no_overlap", {63'd0, pa[k] & pb[k]}, 64'd0);
      end
   end

   // Word-level readback: tail seen before each bit, then one A pass and one B pass
   task automatic model_load(input logic [3:0] lin, input logic [31:0] w, input int nb,
                             output logic [3:0] lout, output logic [31:0] rbo);
      logic [3:0] l;
      l = lin;
      rbo = '0;
      for (int i = nb - 1; i >= 0; i--) begin
         rbo = (rbo << 1) | {31'd0, l[3]};
         l[0] = w[i];
         l[2] = l[1];
         l[1] = l[0];
         l[3] = l[2];
      end
      lout = l;
   endtask

   task automatic do_load(input int k, input logic [31:0] w, input bit keep,
                          input logic [31:0] nxt, input int abort_at, output int waited);
      int nb, pw, gw, t, tot, r, bi;
      logic a, b;
      logic [3:0] new_lat;
      logic [31:0] new_rb;
      nb = nb_of(k);
      pw = pw_of(k);
      gw = gw_of(k);
      t = 1 + 2 * pw + 2 * gw;
      tot = nb * t;
      model_load(mlat[k], w, nb, new_lat, new_rb);
      dat[k] = w;
      vld[k] = 1'b1;
      waited = 0;
      while (!rdy[k] && waited < 200) begin
         @(posedge CLK); #1;
         waited++;
      end
      if (!rdy[k]) begin
         check("handshake_timeout", {63'd0, rdy[k]}, 64'd1);
         vld[k] = 1'b0;
         return;
      end
      @(posedge CLK); #1;
      dat[k] = $urandom;
      vld[k] = keep;
      for (int cyc = 0; cyc <= tot; cyc++) begin
         if (cyc < tot) begin
            r = cyc % t;
            bi = nb - 1 - cyc / t;
            a = (r >= 1 && r < 1 + pw);
            b = (r >= 1 + pw + gw && r < 1 + 2 * pw + gw);
            check("load_cycle", snap(k), pack(exp_rb[k], 1'b1, 1'b0, a, b, w[bi], 1'b0));
            if (cyc == abort_at) begin
               RESET = 1'b1;
               @(posedge CLK); #1;
               return;
            end
         end else begin
            exp_rb[k] = new_rb;
            mlat[k] = new_lat;
            if (keep) dat[k] = nxt;
            check("done_cycle", snap(k), pack(new_rb, 1'b1, 1'b1, 1'b0, 1'b0, w[0], 1'b0));
         end
         @(posedge CLK); #1;
      end
      check("idle_after", snap(k), pack(exp_rb[k], 1'b0, 1'b0, 1'b0, 1'b0, w[0], 1'b1));
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wt;
      logic [31:0] w;
      for (int k = 0; k < ND; k++) begin
         vld[k] = 1'b0;
         dat[k] = '0;
      end
      repeat (3) @(posedge CLK);
      #1;
      for (int k = 0; k < ND; k++) check("in_reset", snap(k), pack(32'd0, 0, 0, 0, 0, 0, 0));
      RESET = 1'b0;
      chain_init = 1'b0;
      #1;
      for (int k = 0; k < ND; k++) begin
         check("after_reset", snap(k), pack(32'd0, 0, 0, 0, 0, 0, 1));
         mlat[k] = 4'b0110;
         exp_rb[k] = '0;
      end
      mon_en = 1'b1;

      // Timing of 1011, then readback of the preloaded and then the shifted chain
      do_load(0, 32'hB, 1'b0, 32'h0, -1, wt);
      do_load(0, 32'h6, 1'b0, 32'h0, -1, wt);
      for (int i = 0; i < 4; i++) do_load(0, 32'($urandom_range(0, 15)), 1'b0, 32'h0, -1, wt);

      // Back-to-back with valid held and data scrambled during the first load
      do_load(0, 32'hA, 1'b1, 32'h5, -1, wt);
      do_load(0, 32'h5, 1'b0, 32'h0, -1, wt);
      check("b2b_wait", 64'(wt), 64'd0);

      // Abort at cycle 7, then a fresh 1111 load
      do_load(0, 32'($urandom_range(0, 15)), 1'b0, 32'h0, 7, wt);
      check("abort_state", snap(0), pack(32'd0, 0, 0, 0, 0, 0, 0));
      RESET = 1'b0;
      #1;
      check("abort_ready", snap(0), pack(32'd0, 0, 0, 0, 0, 0, 1));
      for (int k = 0; k < ND; k++) begin
         mlat[k] = lat[k];
         exp_rb[k] = '0;
      end
      @(posedge CLK); #1;
      check("abort_no_done", snap(0), pack(32'd0, 0, 0, 0, 0, 0, 1));
      do_load(0, 32'hF, 1'b0, 32'h0, -1, wt);
      do_load(0, 32'h3, 1'b0, 32'h0, -1, wt);

      // Single-bit sequencer
      do_load(2, 32'h1, 1'b0, 32'h0, -1, wt);
      do_load(2, 32'h0, 1'b0, 32'h0, -1, wt);
      for (int i = 0; i < 6; i++) do_load(2, 32'($urandom_range(0, 1)), 1'b0, 32'h0, -1, wt);

      // Wide pulses and gaps across many random words
      for (int i = 0; i < 1000; i++) begin
         w = 32'($urandom_range(0, 15));
         do_load(1, w, 1'b0, 32'h0, -1, wt);
      end

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
